// File: rtl/div_sched_pkg.sv
// Shared types and helpers for the shared iterative divider scheduler.
// Imported by the arbiter and the scheduler top.
package div_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        DONE
    } state_t;

    // Wide enough for any DATA_BITS in use; consumers slice the low bits.
    localparam logic [63:0] DIV_BY_ZERO_QUOTIENT = '1;

    // Index width for n items, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/div_scheduler_if.sv
// Thread-side bundle of the divider scheduler: requests and operands in,
// one-hot completion pulse and shared result out.
interface div_scheduler_if #(
    parameter int THREADS_PER_BLOCK = 4,
    parameter int DATA_BITS         = 8
);
    logic [THREADS_PER_BLOCK-1:0]           thread_enable;
    logic [THREADS_PER_BLOCK-1:0]           req;
    logic [THREADS_PER_BLOCK*DATA_BITS-1:0] rs;
    logic [THREADS_PER_BLOCK*DATA_BITS-1:0] rt;
    logic [THREADS_PER_BLOCK-1:0]           done;
    logic [DATA_BITS-1:0]                   quotient;
    logic [DATA_BITS-1:0]                   remainder;
    logic                                   busy;

    modport master (
        output thread_enable, req, rs, rt,
        input  done, quotient, remainder, busy
    );

    modport slave (
        input  thread_enable, req, rs, rt,
        output done, quotient, remainder, busy
    );
endinterface

// File: rtl/div_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
// Returns one-hot grant, its encoded index and a valid flag.
module rr_arbiter
    import div_sched_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] index,
    output logic          valid
);
    always_comb begin
        grant = '0;
        index = '0;
        valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            int            pos;
            logic [IW-1:0] slot;
            pos = int'(ptr) + k;
            if (pos >= N) pos = pos - N;
            slot = IW'(pos);
            if (!valid && req[slot]) begin
                valid       = 1'b1;
                grant[slot] = 1'b1;
                index       = slot;
            end
        end
    end
endmodule

// File: rtl/div_scheduler.sv
// One restoring divider shared by all threads of a core: round-robin grant,
// DATA_BITS iterations per divide, one-hot done pulse with the result.
module div_scheduler
    import div_sched_pkg::*;
#(
    parameter int THREADS_PER_BLOCK = 4,
    parameter int DATA_BITS         = 8
) (
    input  logic           clk,
    input  logic           reset,
    div_scheduler_if.slave bus
);
    localparam int IW = idx_width(THREADS_PER_BLOCK);
    localparam int CW = idx_width(DATA_BITS);
    localparam logic [DATA_BITS-1:0] DBZ_QUOTIENT = DIV_BY_ZERO_QUOTIENT[DATA_BITS-1:0];

    state_t                       state;
    logic [IW-1:0]                ptr;
    logic [IW-1:0]                winner;
    logic [THREADS_PER_BLOCK-1:0] winner_oh;
    logic [CW-1:0]                count;
    logic [DATA_BITS:0]           acc;
    logic [DATA_BITS-1:0]         dividend;
    logic [DATA_BITS-1:0]         divisor;

    logic [THREADS_PER_BLOCK-1:0] eff_req;
    logic [THREADS_PER_BLOCK-1:0] grant;
    logic [IW-1:0]                grant_idx;
    logic                         grant_valid;
    logic [DATA_BITS-1:0]         sel_rs;
    logic [DATA_BITS-1:0]         sel_rt;

    logic [DATA_BITS:0]           acc_shift;
    logic [DATA_BITS:0]           acc_next;
    logic [DATA_BITS-1:0]         dividend_next;
    logic                         fits;

    assign eff_req = bus.req & bus.thread_enable;

    rr_arbiter #(.N(THREADS_PER_BLOCK), .IW(IW)) u_arb (
        .req   (eff_req),
        .ptr   (ptr),
        .grant (grant),
        .index (grant_idx),
        .valid (grant_valid)
    );

    always_comb begin
        sel_rs = '0;
        sel_rt = '0;
        for (int t = 0; t < THREADS_PER_BLOCK; t++) begin
            if (IW'(t) == grant_idx) begin
                sel_rs = bus.rs[t*DATA_BITS +: DATA_BITS];
                sel_rt = bus.rt[t*DATA_BITS +: DATA_BITS];
            end
        end
    end

    // One restoring step; the dividend register fills with quotient bits from the right.
    assign acc_shift     = {acc[DATA_BITS-1:0], dividend[DATA_BITS-1]};
    assign fits          = acc_shift >= {1'b0, divisor};
    assign acc_next      = fits ? acc_shift - {1'b0, divisor} : acc_shift;
    assign dividend_next = {dividend[DATA_BITS-2:0], fits};

    // NOTE: all state and registered outputs update with <= so every branch sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            ptr           <= '0;
            winner        <= '0;
            winner_oh     <= '0;
            count         <= '0;
            acc           <= '0;
            dividend      <= '0;
            divisor       <= '0;
            bus.done      <= '0;
            bus.quotient  <= '0;
            bus.remainder <= '0;
            bus.busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        winner    <= grant_idx;
                        winner_oh <= grant;
                        dividend  <= sel_rs;
                        divisor   <= sel_rt;
                        acc       <= '0;
                        count     <= '0;
                        bus.busy  <= 1'b1;
                        state     <= DIVIDE;
                    end
                end
                DIVIDE: begin
                    acc      <= acc_next;
                    dividend <= dividend_next;
                    count    <= count + 1'b1;
                    if (count == CW'(DATA_BITS - 1)) begin
                        bus.quotient  <= (divisor == '0) ? DBZ_QUOTIENT : dividend_next;
                        bus.remainder <= acc_next[DATA_BITS-1:0];
                        bus.done      <= winner_oh;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    bus.done <= '0;
                    bus.busy <= 1'b0;
                    ptr      <= (winner == IW'(THREADS_PER_BLOCK - 1)) ? '0 : winner + 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/div_scheduler.md
Name: div_scheduler

Overview:
- Shares one iterative 8-bit divider among all thread ALUs of a core, so each thread does not need its own combinational divider.
- Sits between the per-thread ALUs and a single restoring-division datapath.
- Accepts one DIV request per thread, grants round-robin, computes quotient and remainder over DATA_BITS cycles, and returns the result with a one-hot done pulse.

Parameters:
- THREADS_PER_BLOCK, 4, number of requesting threads (2..8).
- DATA_BITS, 8, operand/result width.

Ports:
- clk  input  1  core clock.
- reset  input  1  synchronous, active-high.
- thread_enable  input  THREADS_PER_BLOCK  per-thread active mask; req from a disabled thread is ignored.
- req  input  THREADS_PER_BLOCK  per-thread divide request (level).
- rs  input  THREADS_PER_BLOCK*DATA_BITS  dividends, thread i at bits [i*DATA_BITS +: DATA_BITS].
- rt  input  THREADS_PER_BLOCK*DATA_BITS  divisors, same packing.
- done  output  THREADS_PER_BLOCK  one-hot, one-cycle result-valid pulse.
- quotient  output  DATA_BITS  result of the last completed divide.
- remainder  output  DATA_BITS  remainder of the last completed divide.
- busy  output  1  high in DIVIDE and DONE.

Behaviour:
- Reset values: state IDLE; done=0, quotient=0, remainder=0, busy=0; round-robin pointer=0; iteration counter=0.
- States: IDLE, DIVIDE, DONE.
- Effective request vector = req & thread_enable.
- IDLE:
  - Effective request nonzero at edge E0: winner = first set bit scanning upward from the pointer, wrapping.
  - At E0: latch winner index, rs[winner] and rt[winner]; clear accumulator; counter=0; go to DIVIDE.
  - No request: stay in IDLE.
- DIVIDE (edges E1..E_DATA_BITS):
  - Each edge performs one restoring step, MSB first: shift {acc, dividend} left 1; if acc >= divisor, subtract and set quotient bit to 1.
  - Accumulator is DATA_BITS+1 wide to avoid overflow on the compare.
  - Counter increments each edge; on the final step (E_DATA_BITS), register quotient/remainder outputs, set done[winner]=1, go to DONE.
- DONE (one cycle):
  - done is high during this cycle only.
  - At the next edge: done clears, pointer = (winner+1) mod THREADS_PER_BLOCK, go to IDLE.
- Latency: result and done are visible DATA_BITS cycles after the grant edge (8 by default). Throughput is one divide per DATA_BITS+2 cycles.
- Requester contract:
  - Hold req and operands stable until done[i] is seen; deassert req in the done cycle.
  - The DONE state ignores req. A re-request is sampled no earlier than the IDLE edge after DONE.
- Operands are sampled only at grant. Changes during DIVIDE have no effect.
- Divide by zero: quotient = all ones (8'hFF), remainder = dividend. The full iteration count still runs, so latency is unchanged.
- Requests arriving during DIVIDE/DONE wait; no request is dropped while held.
- thread_enable dropping for the winner mid-operation: the operation completes and done still pulses.
- Reset mid-operation: abort immediately, no done pulse, pointer returns to 0, outputs return to 0.
- quotient/remainder hold their value until the next completion.
- Simultaneous requests: exactly one grant per arbitration. Starvation-free: each requester waits at most THREADS_PER_BLOCK-1 operations.

Decomposition:
- Package div_sched_pkg:
  - State enum (IDLE, DIVIDE, DONE).
  - DIV_BY_ZERO_QUOTIENT constant (all ones).
  - Function or localparam for index width: clog2(THREADS_PER_BLOCK).
- Sub-module rr_arbiter:
  - Combinational pick of the first set bit from a pointer, with wrap.
  - Outputs the one-hot grant and encoded index; reused elsewhere for memory-port arbitration.
- FSM, counter and restoring datapath stay in div_scheduler.

Test Plan:
- Single request: thread 2, rs=200, rt=7 → done=4'b0100 pulses 8 cycles after grant; quotient=28, remainder=4; busy high 9 cycles.
- Divide by zero: thread 0, rs=55, rt=0 → quotient=8'hFF, remainder=55, same latency.
- Contention: all 4 threads request together, operands (100,10), (9,3), (255,16), (7,8) → done order threads 0,1,2,3; results (10,0), (3,0), (15,15), (0,7); the two done pulses are 10 cycles apart.
- Fairness: after thread 1 is served, threads 0 and 1 both request → thread 2 is skipped (no req), thread 0 is granted first, then thread 1.
- Masking and reset: req=4'b1000 with thread_enable=4'b0111 → no grant. Then grant thread 1 and assert reset at iteration 4 → no done pulse, outputs 0, next grant scans from thread 0.
